// File: rtl/axi2apb_64_32.sv
// axi2apb_64_32: serialises 64-bit AXI4 bursts into 32-bit APB transfers, one transaction at a time
module axi2apb_64_32 #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 16,
    parameter int AXI_USER_WIDTH = 10,
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ID_WIDTH-1:0]   aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
    input  logic [7:0]                aw_len,
    input  logic [2:0]                aw_size,
    input  logic [1:0]                aw_burst,
    input  logic                      aw_valid,
    output logic                      aw_ready,
    input  logic [63:0]               w_data,
    input  logic [7:0]                w_strb,
    input  logic                      w_last,
    input  logic                      w_valid,
    output logic                      w_ready,
    output logic [AXI_ID_WIDTH-1:0]   b_id,
    output logic [1:0]                b_resp,
    output logic [AXI_USER_WIDTH-1:0] b_user,
    output logic                      b_valid,
    input  logic                      b_ready,
    input  logic [AXI_ID_WIDTH-1:0]   ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
    input  logic [7:0]                ar_len,
    input  logic [2:0]                ar_size,
    input  logic [1:0]                ar_burst,
    input  logic                      ar_valid,
    output logic                      ar_ready,
    output logic [AXI_ID_WIDTH-1:0]   r_id,
    output logic [63:0]               r_data,
    output logic [1:0]                r_resp,
    output logic                      r_last,
    output logic [AXI_USER_WIDTH-1:0] r_user,
    output logic                      r_valid,
    input  logic                      r_ready,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic [31:0]               pwdata,
    output logic [3:0]                pstrb,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    input  logic [31:0]               prdata,
    input  logic                      pready,
    input  logic                      pslverr
);
    typedef enum logic [2:0] {IDLE, W_WAIT, SETUP, ACCESS, B_RESP, R_RESP} state_t;
    state_t state_q, state_d;
    logic rr_q, rr_d, wr_q, wr_d, half_q, half_d, err_q, err_d, berr_q, berr_d;
    logic [AXI_ID_WIDTH-1:0] id_q, id_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d, step, wrap_mask, addr_nxt;
    logic [7:0] len_q, len_d, beat_q, beat_d, wstrb_q, wstrb_d;
    logic [2:0] size_q, size_d;
    logic [1:0] burst_q, burst_d;
    logic [63:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic grant_w, beat_done, last_beat, unused;
    assign unused    = w_last;
    assign step      = AXI_ADDR_WIDTH'(1) << size_q;
    assign wrap_mask = ((AXI_ADDR_WIDTH'(len_q) + AXI_ADDR_WIDTH'(1)) << size_q) - AXI_ADDR_WIDTH'(1);
    assign addr_nxt  = burst_q == 2'b00 ? addr_q :
                       burst_q == 2'b10 ? (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask) :
                       addr_q + step;
    assign grant_w   = aw_valid && (!ar_valid || !rr_q);
    assign beat_done = half_q || size_q != 3'd3;
    assign last_beat = beat_q == len_q;
    assign aw_ready  = state_q == IDLE && grant_w;
    assign ar_ready  = state_q == IDLE && ar_valid && !grant_w;
    assign w_ready   = state_q == W_WAIT;
    assign psel      = state_q == SETUP || state_q == ACCESS;
    assign penable   = state_q == ACCESS;
    assign paddr     = {addr_q[APB_ADDR_WIDTH-1:3], half_q, 2'b00};
    assign pwdata    = half_q ? wdata_q[63:32] : wdata_q[31:0];
    assign pstrb     = half_q ? wstrb_q[7:4] : wstrb_q[3:0];
    assign pwrite    = wr_q;
    assign b_valid   = state_q == B_RESP;
    assign b_id      = id_q;
    assign b_resp    = {berr_q, 1'b0};
    assign b_user    = '0;
    assign r_valid   = state_q == R_RESP;
    assign r_id      = id_q;
    assign r_data    = rdata_q;
    assign r_resp    = {err_q, 1'b0};
    assign r_last    = r_valid && last_beat;
    assign r_user    = '0;

    // next-state: arbitration, W capture, APB sequencing, beat address and response bookkeeping
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        wr_d    = wr_q;
        half_d  = half_q;
        err_d   = err_q;
        berr_d  = berr_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        size_d  = size_q;
        burst_d = burst_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (aw_valid || ar_valid) begin
                rr_d    = grant_w;
                wr_d    = grant_w;
                id_d    = grant_w ? aw_id : ar_id;
                addr_d  = grant_w ? aw_addr : ar_addr;
                len_d   = grant_w ? aw_len : ar_len;
                size_d  = grant_w ? aw_size : ar_size;
                burst_d = grant_w ? aw_burst : ar_burst;
                half_d  = ar_size != 3'd3 && ar_addr[2];
                beat_d  = '0;
                err_d   = 1'b0;
                berr_d  = 1'b0;
                rdata_d = '0;
                state_d = grant_w ? W_WAIT : SETUP;
            end
            W_WAIT: if (w_valid) begin
                wdata_d = w_data;
                wstrb_d = w_strb;
                half_d  = size_q != 3'd3 && addr_q[2];
                state_d = SETUP;
            end
            SETUP: state_d = ACCESS;
            ACCESS: if (pready) begin
                err_d  = err_q | pslverr;
                berr_d = berr_q | pslverr;
                if (!wr_q) rdata_d = half_q ? {prdata, rdata_q[31:0]} : {rdata_q[63:32], prdata};
                if (!beat_done) begin
                    half_d  = 1'b1;
                    state_d = SETUP;
                end else begin
                    addr_d  = addr_nxt;
                    beat_d  = wr_q ? beat_q + 8'd1 : beat_q;
                    state_d = !wr_q ? R_RESP : last_beat ? B_RESP : W_WAIT;
                end
            end
            R_RESP: if (r_ready) begin
                beat_d  = beat_q + 8'd1;
                half_d  = size_q != 3'd3 && addr_q[2];
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = last_beat ? IDLE : SETUP;
            end
            B_RESP: if (b_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            wr_q    <= 1'b0;
            half_q  <= 1'b0;
            err_q   <= 1'b0;
            berr_q  <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            half_q  <= half_d;
            err_q   <= err_d;
            berr_q  <= berr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_axi2apb_64_32.sv
// tb_axi2apb_64_32: scoreboard bench with an APB slave model and a transaction-level reference model
module tb_axi2apb_64_32;
    logic clk = 0, rst = 1;
    logic [15:0] aw_id = 0, ar_id = 0, b_id, r_id;
    logic [31:0] aw_addr = 0, ar_addr = 0;
    logic [7:0] aw_len = 0, ar_len = 0, w_strb = 0;
    logic [2:0] aw_size = 0, ar_size = 0;
    logic [1:0] aw_burst = 0, ar_burst = 0, b_resp, r_resp;
    logic aw_valid = 0, aw_ready, w_last = 0, w_valid = 0, w_ready, b_valid, b_ready = 0;
    logic ar_valid = 0, ar_ready, r_last, r_valid, r_ready = 0;
    logic [63:0] w_data = 0, r_data;
    logic [9:0] b_user, r_user;
    logic [11:0] paddr;
    logic [31:0] pwdata, prdata = 0;
    logic [3:0] pstrb;
    logic pwrite, psel, penable, pready = 0, pslverr = 0;

    typedef struct { logic [11:0] a; logic wr; logic [31:0] wd; logic [3:0] ws; logic [31:0] rd; logic err; } apb_t;
    typedef struct { logic [15:0] id; logic [63:0] d; logic [1:0] resp; logic last; } r_t;
    typedef struct { logic [15:0] id; logic [1:0] resp; } b_t;
    typedef struct { logic [63:0] d; logic [7:0] s; } w_t;

    apb_t apb_q[$];
    r_t r_q[$];
    b_t b_q[$];
    w_t w_drv_q[$];
    logic [31:0] dir_rd[$];
    logic dir_err[$];
    logic [63:0] dir_wd[$];
    logic [7:0] dir_ws[$];
    apb_t cur;
    r_t re;
    b_t be;
    w_t wb;
    int checks = 0, errors = 0, lat;
    bit wr_next = 1, no_stall = 0;

    axi2apb_64_32 dut (
        .clk(clk), .rst(rst),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
        .r_valid(r_valid), .r_ready(r_ready),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pwrite(pwrite), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Expected APB transfers, R beats and B response of one transaction, from the burst rules
    task automatic model(input logic wr, input logic [15:0] id, input logic [31:0] a, input int len,
                         input int sz, input logic [1:0] bu);
        int step = 1 << sz;
        logic [31:0] t = 32'((len + 1) * step);
        logic berr = 0;
        wr_next = !wr;
        for (int i = 0; i <= len; i++) begin
            logic [31:0] ba = bu == 2'd0 ? a : bu == 2'd2 ? (a - a % t) + ((a % t + 32'(i * step)) % t)
                                                          : a + 32'(i * step);
            logic [63:0] d = 0, rdv = 0;
            logic [7:0] s = 0;
            logic eb = 0;
            if (wr) begin
                d = dir_wd.size() != 0 ? dir_wd.pop_front() : {$urandom, $urandom};
                s = dir_ws.size() != 0 ? dir_ws.pop_front() : 8'($urandom);
                w_drv_q.push_back('{d, s});
            end
            for (int h = 0; h < 2; h++) begin
                if (sz == 3 || h == int'(ba[2])) begin
                    apb_t e;
                    e.a = {ba[11:3], h[0], 2'b00};
                    e.wr = wr;
                    e.wd = d[h*32 +: 32];
                    e.ws = s[h*4 +: 4];
                    e.rd = dir_rd.size() != 0 ? dir_rd.pop_front() : $urandom;
                    e.err = dir_err.size() != 0 ? dir_err.pop_front() : ($urandom_range(0, 7) == 0);
                    rdv[h*32 +: 32] = e.rd;
                    eb |= e.err;
                    apb_q.push_back(e);
                end
            end
            berr |= eb;
            if (!wr) r_q.push_back('{id, rdv, eb ? 2'b10 : 2'b00, i == len});
        end
        if (wr) b_q.push_back('{id, berr ? 2'b10 : 2'b00});
    endtask

    task automatic drive_ar(input logic [15:0] id, input logic [31:0] a, input int len, input int sz, input logic [1:0] bu);
        ar_id = id; ar_addr = a; ar_len = 8'(len); ar_size = 3'(sz); ar_burst = bu; ar_valid = 1;
        #1;
        for (int t = 0; t < 2000 && !ar_ready; t++) begin @(negedge clk); #1; end
        chk("ar_handshake", ar_ready, 1);
        @(negedge clk);
        ar_valid = 0;
    endtask

    task automatic drive_wr(input logic [15:0] id, input logic [31:0] a, input int len, input int sz, input logic [1:0] bu);
        aw_id = id; aw_addr = a; aw_len = 8'(len); aw_size = 3'(sz); aw_burst = bu; aw_valid = 1;
        #1;
        for (int t = 0; t < 2000 && !aw_ready; t++) begin @(negedge clk); #1; end
        chk("aw_handshake", aw_ready, 1);
        @(negedge clk);
        aw_valid = 0;
        for (int i = 0; i <= len; i++) begin
            if (w_drv_q.size() != 0) wb = w_drv_q.pop_front();
            w_data = wb.d; w_strb = wb.s; w_last = i == len; w_valid = 1;
            #1;
            for (int t = 0; t < 2000 && !w_ready; t++) begin @(negedge clk); #1; end
            chk("w_handshake", w_ready, 1);
            @(negedge clk);
            w_valid = 0;
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while ((apb_q.size() != 0 || r_q.size() != 0 || b_q.size() != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("txn_complete", t < 5000, 1);
        @(negedge clk);
    endtask

    task automatic arb_round();
        logic [15:0] iw = 16'($urandom), ir = 16'($urandom);
        if (wr_next) begin
            model(1, iw, 32'h400, 1, 3, 2'd1);
            model(0, ir, 32'h500, 0, 2, 2'd1);
        end else begin
            model(0, ir, 32'h500, 0, 2, 2'd1);
            model(1, iw, 32'h400, 1, 3, 2'd1);
        end
        fork
            drive_wr(iw, 32'h400, 1, 3, 2'd1);
            drive_ar(ir, 32'h500, 0, 2, 2'd1);
        join
        wait_done();
    endtask

    task automatic run_random(input int n);
        for (int k = 0; k < n; k++) begin
            logic wr = 1'($urandom_range(0, 1));
            int sz = $urandom_range(0, 3);
            logic [1:0] bu = 2'($urandom_range(0, 2));
            int len = bu == 2'd2 ? (2 << $urandom_range(0, 2)) - 1 : $urandom_range(0, 7);
            logic [31:0] a = ($urandom & 32'h0000_3FFF) & ~((32'd1 << sz) - 32'd1);
            logic [15:0] id = 16'($urandom);
            model(wr, id, a, len, sz, bu);
            if (wr) drive_wr(id, a, len, sz, bu);
            else drive_ar(id, a, len, sz, bu);
            wait_done();
        end
    endtask

    // APB slave: checks each request against the expected transfer list and answers with random stalls
    initial forever begin
        @(negedge clk);
        if (psel && !penable) begin
            if (apb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL apb_unexpected paddr=%h pwrite=%b", paddr, pwrite);
            end else begin
                cur = apb_q.pop_front();
                chk("paddr", paddr, cur.a);
                chk("pwrite", pwrite, cur.wr);
                if (cur.wr) begin
                    chk("pwdata", pwdata, cur.wd);
                    chk("pstrb", pstrb, cur.ws);
                end
            end
            pready = 0;
        end else if (psel && penable) begin
            chk("paddr_hold", paddr, cur.a);
            chk("pwrite_hold", pwrite, cur.wr);
            if (cur.wr) chk("pwdata_hold", pwdata, cur.wd);
            pready = no_stall || $urandom_range(0, 2) == 0;
            prdata = pready ? cur.rd : $urandom;
            pslverr = pready ? cur.err : 1'($urandom);
        end else pready = 0;
    end

    // AXI response monitor with random backpressure
    initial forever begin
        @(negedge clk);
        r_ready = $urandom_range(0, 3) != 0;
        b_ready = $urandom_range(0, 3) != 0;
        if (r_valid && r_ready) begin
            if (r_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL r_unexpected r_id=%h r_data=%h", r_id, r_data);
            end else begin
                re = r_q.pop_front();
                chk("r_id", r_id, re.id);
                chk("r_data", r_data, re.d);
                chk("r_resp", r_resp, re.resp);
                chk("r_last", r_last, re.last);
            end
        end
        if (b_valid && b_ready) begin
            if (b_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected b_id=%h b_resp=%h", b_id, b_resp);
            end else begin
                be = b_q.pop_front();
                chk("b_id", b_id, be.id);
                chk("b_resp", b_resp, be.resp);
                chk("b_after_apb", apb_q.size(), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_aw_ready", aw_ready, 0);
        chk("rst_ar_ready", ar_ready, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_last", r_last, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_r_data", r_data, 0);
        rst = 0;
        @(negedge clk);
        dir_rd.push_back(32'h1111_1111); dir_rd.push_back(32'h2222_2222);
        dir_err.push_back(0); dir_err.push_back(0);
        model(0, 16'h1234, 32'h100, 0, 3, 2'd1);
        drive_ar(16'h1234, 32'h100, 0, 3, 2'd1);
        wait_done();
        dir_wd.push_back(64'hAAAA_BBBB_CCCC_DDDD); dir_ws.push_back(8'hF0);
        dir_err.push_back(0); dir_err.push_back(0);
        model(1, 16'h0BEE, 32'h08, 0, 3, 2'd1);
        drive_wr(16'h0BEE, 32'h08, 0, 3, 2'd1);
        wait_done();
        model(0, 16'h0303, 32'h200, 3, 3, 2'd1);
        drive_ar(16'h0303, 32'h200, 3, 3, 2'd1);
        wait_done();
        dir_err.push_back(0); dir_err.push_back(1); dir_err.push_back(0); dir_err.push_back(0);
        model(1, 16'h0404, 32'h300, 1, 3, 2'd1);
        drive_wr(16'h0404, 32'h300, 1, 3, 2'd1);
        wait_done();
        repeat (3) arb_round();
        no_stall = 1;
        model(0, 16'h0505, 32'h44, 0, 2, 2'd1);
        drive_ar(16'h0505, 32'h44, 0, 2, 2'd1);
        lat = 1;
        while (!r_valid && lat < 50) begin @(negedge clk); lat++; end
        chk("rd_latency", lat, 3);
        wait_done();
        no_stall = 0;
        model(0, 16'h0D0D, 32'h600, 3, 3, 2'd1);
        drive_ar(16'h0D0D, 32'h600, 3, 3, 2'd1);
        for (int t = 0; t < 200 && !(psel && penable); t++) @(negedge clk);
        chk("pre_reset_access", psel && penable, 1);
        rst = 1;
        #1;
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_penable", penable, 0);
        apb_q.delete(); r_q.delete(); b_q.delete(); w_drv_q.delete();
        wr_next = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        model(0, 16'h0E0E, 32'h700, 1, 3, 2'd1);
        drive_ar(16'h0E0E, 32'h700, 1, 3, 2'd1);
        wait_done();
        run_random(40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
